adc_seq_ctrl: RTL and testbench

//  Parametrised successor ADC conversion/readout sequencer for the parallel-bus ADC on the 1.8V bank.

---
 rtl/adc_pkg.sv | 40 ++++
 rtl/adc_eoc_sync.sv | 32 +++
 rtl/adc_seq_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_adc_seq_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// -----------------------------------------------------------------------------
// adc_pkg
//   Shared definitions for the parallel-bus ADC blocks on the 1.8V bank.
//   Holds the sequencer state encoding, the channel-index width, the default
//   timing constants (in clk_100M cycles) and a small helper used to size the
//   shared timing counter from whichever timing parameter is largest.
// -----------------------------------------------------------------------------
package adc_pkg;

   // Sequencer states. IDLE must stay the reset/abort state.
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CONV     = 3'd1,
      WAIT_EOC = 3'd2,
      SETUP    = 3'd3,
      RD       = 3'd4,
      HOLD     = 3'd5,
      GAP      = 3'd6
   } adc_state_t;

   // Channel index width: up to 8 words per conversion.
   localparam int CH_W = 3;

   // Default timing, whole clk_100M cycles.
   localparam int DEF_DATA_W      = 12;
   localparam int DEF_NUM_CH      = 4;
   localparam int DEF_CONV_LOW    = 4;
   localparam int DEF_RD_SETUP    = 3;
   localparam int DEF_RD_LOW      = 6;
   localparam int DEF_RD_GAP      = 4;
   localparam int DEF_EOC_TIMEOUT = 255;

   // Depth of the EOC synchroniser.
   localparam int EOC_SYNC_STAGES = 2;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/adc_eoc_sync.sv
// -----------------------------------------------------------------------------
// adc_eoc_sync
//   Two-flop synchroniser for the ADC end-of-conversion line. EOC is active
//   low, so the chain resets to 1 (no conversion finished).
// Ports
//   clk_100M   in   system clock
//   Reset      in   async, active-low reset
//   eoc_async  in   raw EOC_18 from the pad
//   eoc_sync   out  EOC in the clk_100M domain, 2 cycles of latency
// -----------------------------------------------------------------------------
module adc_eoc_sync
   import adc_pkg::*;
(
   input  logic clk_100M,
   input  logic Reset,
   input  logic eoc_async,
   output logic eoc_sync
);

   logic [EOC_SYNC_STAGES-1:0] sync_reg;

   always_ff @(posedge clk_100M or negedge Reset) begin
      if (!Reset) begin
         sync_reg <= '1;
      end else begin
         sync_reg <= {sync_reg[EOC_SYNC_STAGES-2:0], eoc_async};
      end
   end

   assign eoc_sync = sync_reg[EOC_SYNC_STAGES-1];

endmodule

// File: rtl/adc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// adc_seq_ctrl
//   Conversion/readout sequencer for the parallel-bus ADC. Fires CONVST, waits
//   for EOC (with timeout), then reads NUM_CH words with timed RD pulses and
//   hands each word to a valid/ready stream. Supports backpressure, abort via
//   PD_in and continuous back-to-back conversions.
// Ports
//   clk_100M     in   100 MHz system clock
//   Reset        in   async, active-low reset
//   start        in   1-cycle conversion request (only honoured in IDLE)
//   continuous   in   restart automatically after the last word is accepted
//   PD_in        in   power-up request; 0 powers down and aborts
//   EOC_18       in   ADC end-of-conversion, active low, asynchronous
//   DB_18        in   ADC data bus
//   CONVST_18    out  convert start, active-low pulse
//   RD_18        out  read strobe, active low
//   PD_18        out  ADC power control (PD_in gated by reset)
//   out_valid    out  captured word available
//   out_ready    in   downstream accept
//   out_data     out  captured word
//   out_ch       out  channel index of out_data
//   busy         out  high in every state except IDLE
//   timeout_err  out  1-cycle pulse when EOC never arrives
// -----------------------------------------------------------------------------
module adc_seq_ctrl
   import adc_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int NUM_CH      = DEF_NUM_CH,
   parameter int CONV_LOW    = DEF_CONV_LOW,
   parameter int RD_SETUP    = DEF_RD_SETUP,
   parameter int RD_LOW      = DEF_RD_LOW,
   parameter int RD_GAP      = DEF_RD_GAP,
   parameter int EOC_TIMEOUT = DEF_EOC_TIMEOUT
)
(
   input  logic              clk_100M,
   input  logic              Reset,
   input  logic              start,
   input  logic              continuous,
   input  logic              PD_in,
   input  logic              EOC_18,
   input  logic [DATA_W-1:0] DB_18,
   output logic              CONVST_18,
   output logic              RD_18,
   output logic              PD_18,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CH_W-1:0]   out_ch,
   output logic              busy,
   output logic              timeout_err
);

   // One down-counter serves every timed phase, so it is sized for the
   // largest timing parameter.
   localparam int CNT_MAX = max_int(max_int(max_int(CONV_LOW, RD_SETUP),
                                            max_int(RD_LOW, RD_GAP)),
                                    EOC_TIMEOUT);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] CONV_LOAD  = CNT_W'(CONV_LOW - 1);
   localparam logic [CNT_W-1:0] EOC_LOAD   = CNT_W'(EOC_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(RD_SETUP - 1);
   localparam logic [CNT_W-1:0] RD_LOAD    = CNT_W'(RD_LOW - 1);
   // The accept cycle already counts as the first high cycle of the gap,
   // so the GAP state itself only needs RD_GAP-1 cycles.
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(RD_GAP - 2);
   localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);

   adc_state_t       state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CH_W-1:0]  ch_reg;
   logic             eoc_sync;

   adc_eoc_sync u_eoc_sync (
      .clk_100M  (clk_100M),
      .Reset     (Reset),
      .eoc_async (EOC_18),
      .eoc_sync  (eoc_sync)
   );

   // ADC stays powered down while in reset; otherwise follow the request.
   assign PD_18 = Reset & PD_in;

   always_ff @(posedge clk_100M or negedge Reset) begin
      if (!Reset) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         ch_reg      <= '0;
         CONVST_18   <= 1'b1;
         RD_18       <= 1'b1;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_ch      <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= 1'b0;

         if (!PD_in) begin
            // Power-down wins over everything, including a same-cycle start.
            // A word waiting in HOLD is discarded.
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ch_reg    <= '0;
            CONVST_18 <= 1'b1;
            RD_18     <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (start) begin
                     state_reg <= CONV;
                     CONVST_18 <= 1'b0;
                     cnt_reg   <= CONV_LOAD;
                     ch_reg    <= '0;
                     busy      <= 1'b1;
                  end
               end

               CONV: begin
                  if (cnt_reg == '0) begin
                     state_reg <= WAIT_EOC;
                     CONVST_18 <= 1'b1;
                     cnt_reg   <= EOC_LOAD;
                  end else begin
                     cnt_reg <= cnt_reg - 1'b1;
                  end
               end

               WAIT_EOC: begin
                  // An EOC seen in the final timeout cycle still counts.
                  if (!eoc_sync) begin
                     state_reg <= SETUP;
                     cnt_reg   <= SETUP_LOAD;
                  end else if (cnt_reg == '0) begin
                     state_reg   <= IDLE;
                     timeout_err <= 1'b1;
                     busy        <= 1'b0;
                  end else begin
                     cnt_reg <= cnt_reg - 1'b1;
                  end
               end

               SETUP: begin
                  if (cnt_reg == '0) begin
                     state_reg <= RD;
                     RD_18     <= 1'b0;
                     cnt_reg   <= RD_LOAD;
                  end else begin
                     cnt_reg <= cnt_reg - 1'b1;
                  end
               end

               RD: begin
                  // Sample on the edge that ends the last low cycle, so the
                  // bus has had the full RD low time to settle.
                  if (cnt_reg == '0) begin
                     state_reg <= HOLD;
                     RD_18     <= 1'b1;
                     out_valid <= 1'b1;
                     out_data  <= DB_18;
                     out_ch    <= ch_reg;
                  end else begin
                     cnt_reg <= cnt_reg - 1'b1;
                  end
               end

               HOLD: begin
                  if (out_ready) begin
                     out_valid <= 1'b0;
                     if (ch_reg != LAST_CH) begin
                        ch_reg <= ch_reg + 1'b1;
                        if (RD_GAP == 1) begin
                           state_reg <= RD;
                           RD_18     <= 1'b0;
                           cnt_reg   <= RD_LOAD;
                        end else begin
                           state_reg <= GAP;
                           cnt_reg   <= GAP_LOAD;
                        end
                     end else if (continuous) begin
                        state_reg <= CONV;
                        CONVST_18 <= 1'b0;
                        cnt_reg   <= CONV_LOAD;
                        ch_reg    <= '0;
                     end else begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                     end
                  end
               end

               GAP: begin
                  if (cnt_reg == '0) begin
                     state_reg <= RD;
                     RD_18     <= 1'b0;
                     cnt_reg   <= RD_LOAD;
                  end else begin
                     cnt_reg <= cnt_reg - 1'b1;
                  end
               end

               default: begin
                  state_reg <= IDLE;
                  CONVST_18 <= 1'b1;
                  RD_18     <= 1'b1;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_adc_seq_ctrl
//   Directed + randomised bench for adc_seq_ctrl. Expected event times are
//   derived from the timing rules as plain cycle arithmetic on a timeline;
//   a negedge monitor records what the DUT actually did.
// -----------------------------------------------------------------------------
module tb_adc_seq_ctrl;

   localparam int DATA_W      = 12;
   localparam int NUM_CH      = 4;
   localparam int CONV_LOW    = 4;
   localparam int RD_SETUP    = 3;
   localparam int RD_LOW      = 6;
   localparam int RD_GAP      = 4;
   localparam int EOC_TIMEOUT = 255;
   // EOC driven low before edge e is seen by the sequencer at edge e+3
   // (two synchroniser flops plus the state transition itself).
   localparam int SYNC_LAT    = 3;
   localparam int EOC_LOW_LEN = 4;

   logic              clk_100M = 1'b0;
   logic              Reset = 1'b0;
   logic              start = 1'b0;
   logic              continuous = 1'b0;
   logic              PD_in = 1'b1;
   logic              EOC_18 = 1'b1;
   logic [DATA_W-1:0] DB_18 = '0;
   logic              out_ready = 1'b0;
   logic              CONVST_18, RD_18, PD_18, out_valid, busy, timeout_err;
   logic [DATA_W-1:0] out_data;
   logic [2:0]        out_ch;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int viol = 0;

   // Stimulus description for the next run.
   int d_q[$];      // EOC delay per conversion, cycles after CONVST rises
   int st_q[$];     // stall cycles per word
   int dat_q[$];    // word value per word

   // Model timeline.
   int sch_start, sch_end, last_cf;
   int eoc_q[$], db_cyc_q[$];
   int exp_cf[$], exp_cr[$], exp_rf[$], exp_rr[$], exp_acc[$];
   int exp_data[$], exp_ch[$], exp_br[$], exp_bf[$], exp_to[$];

   // Observed timeline.
   int got_cf[$], got_cr[$], got_rf[$], got_rr[$], got_vr[$], got_acc[$];
   int got_data[$], got_ch[$], got_br[$], got_bf[$], got_to[$];

   adc_seq_ctrl #(
      .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CONV_LOW(CONV_LOW),
      .RD_SETUP(RD_SETUP), .RD_LOW(RD_LOW), .RD_GAP(RD_GAP),
      .EOC_TIMEOUT(EOC_TIMEOUT)
   ) dut (
      .clk_100M    (clk_100M),
      .Reset       (Reset),
      .start       (start),
      .continuous  (continuous),
      .PD_in       (PD_in),
      .EOC_18      (EOC_18),
      .DB_18       (DB_18),
      .CONVST_18   (CONVST_18),
      .RD_18       (RD_18),
      .PD_18       (PD_18),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_ch      (out_ch),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk_100M = ~clk_100M;
   always @(posedge clk_100M) cyc <= cyc + 1;

   // Monitor: at the negedge after posedge n, cyc == n and outputs show edge n.
   logic prev_cv = 1'b1, prev_rd = 1'b1, prev_v = 1'b0, prev_b = 1'b0;
   logic [DATA_W-1:0] prev_d = '0;
   logic [2:0]        prev_c = '0;
   always @(negedge clk_100M) begin
      if (prev_cv && !CONVST_18) got_cf.push_back(cyc);
      if (!prev_cv && CONVST_18) got_cr.push_back(cyc);
      if (prev_rd && !RD_18) got_rf.push_back(cyc);
      if (!prev_rd && RD_18) got_rr.push_back(cyc);
      if (!prev_v && out_valid) got_vr.push_back(cyc);
      if (!prev_b && busy) got_br.push_back(cyc);
      if (prev_b && !busy) got_bf.push_back(cyc);
      if (timeout_err) got_to.push_back(cyc);
      if (out_valid && out_ready) begin
         got_acc.push_back(cyc);
         got_data.push_back(int'(out_data));
         got_ch.push_back(int'(out_ch));
      end
      if (prev_v && out_valid && (out_data !== prev_d || out_ch !== prev_c)) viol++;
      prev_cv = CONVST_18; prev_rd = RD_18; prev_v = out_valid; prev_b = busy;
      prev_d = out_data; prev_c = out_ch;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic cmp_q(input string tag, input int got[$], input int expq[$]);
      chk({tag, "_count"}, got.size(), expq.size());
      for (int i = 0; i < got.size() && i < expq.size(); i++)
         chk($sformatf("%s[%0d]", tag, i), got[i], expq[i]);
   endtask

   task automatic step();
      @(posedge clk_100M);
      #1;
   endtask

   task automatic clear_all();
      eoc_q.delete(); db_cyc_q.delete();
      exp_cf.delete(); exp_cr.delete(); exp_rf.delete(); exp_rr.delete();
      exp_acc.delete(); exp_data.delete(); exp_ch.delete();
      exp_br.delete(); exp_bf.delete(); exp_to.delete();
      got_cf.delete(); got_cr.delete(); got_rf.delete(); got_rr.delete();
      got_vr.delete(); got_acc.delete(); got_data.delete(); got_ch.delete();
      got_br.delete(); got_bf.delete(); got_to.delete();
   endtask

   task automatic idle_inputs();
      start = 1'b0; continuous = 1'b0; EOC_18 = 1'b1; out_ready = 1'b0;
   endtask

   // Timeline of nconv chained conversions (start issued at the next step).
   task automatic build_model(input int nconv);
      int t, cf, rf, rr, acc, w, e;
      clear_all();
      sch_start = cyc + 1;
      t = sch_start + 1;
      cf = t; acc = t; w = 0;
      for (int c = 0; c < nconv; c++) begin
         cf = t;
         exp_cf.push_back(cf);
         exp_cr.push_back(cf + CONV_LOW);
         e = cf + CONV_LOW + d_q[c];
         eoc_q.push_back(e);
         rf = e + SYNC_LAT + RD_SETUP;
         for (int k = 0; k < NUM_CH; k++) begin
            rr = rf + RD_LOW;
            exp_rf.push_back(rf);
            exp_rr.push_back(rr);
            db_cyc_q.push_back(rr - 1);
            acc = rr + st_q[w];
            exp_acc.push_back(acc);
            exp_data.push_back(dat_q[w]);
            exp_ch.push_back(k);
            rf = acc + RD_GAP;
            w++;
         end
         t = acc + 1;
      end
      last_cf = cf;
      sch_end = t;
      exp_br.push_back(sch_start + 1);
      exp_bf.push_back(sch_end);
   endtask

   task automatic build_timeout();
      int cf;
      clear_all();
      sch_start = cyc + 1;
      cf = sch_start + 1;
      last_cf = cf;
      exp_cf.push_back(cf);
      exp_cr.push_back(cf + CONV_LOW);
      exp_to.push_back(cf + CONV_LOW + EOC_TIMEOUT);
      exp_br.push_back(cf);
      exp_bf.push_back(cf + CONV_LOW + EOC_TIMEOUT);
      sch_end = cf + CONV_LOW + EOC_TIMEOUT;
   endtask

   // Inputs for the cycle that starts at posedge n.
   task automatic apply(input int n);
      start = (n == sch_start);
      EOC_18 = 1'b1;
      foreach (eoc_q[i]) if (n >= eoc_q[i] && n < eoc_q[i] + EOC_LOW_LEN) EOC_18 = 1'b0;
      out_ready = 1'b0;
      foreach (exp_acc[i]) if (n == exp_acc[i]) out_ready = 1'b1;
      DB_18 = DATA_W'($urandom);
      foreach (db_cyc_q[i]) if (n == db_cyc_q[i]) DB_18 = DATA_W'(exp_data[i]);
      continuous = (n < last_cf);
   endtask

   task automatic run_until(input int stop);
      while (cyc < stop) begin
         step();
         apply(cyc);
      end
   endtask

   task automatic check_events(input string tag);
      cmp_q({tag, ".convst_fall"}, got_cf, exp_cf);
      cmp_q({tag, ".convst_rise"}, got_cr, exp_cr);
      cmp_q({tag, ".rd_fall"}, got_rf, exp_rf);
      cmp_q({tag, ".rd_rise"}, got_rr, exp_rr);
      cmp_q({tag, ".valid_rise"}, got_vr, exp_rr);
      cmp_q({tag, ".accept"}, got_acc, exp_acc);
      cmp_q({tag, ".data"}, got_data, exp_data);
      cmp_q({tag, ".ch"}, got_ch, exp_ch);
      cmp_q({tag, ".busy_rise"}, got_br, exp_br);
      cmp_q({tag, ".busy_fall"}, got_bf, exp_bf);
      cmp_q({tag, ".timeout"}, got_to, exp_to);
      chk({tag, ".hold_stable_viol"}, viol, 0);
   endtask

   task automatic fill_random(input int nconv, input int max_stall);
      d_q.delete(); st_q.delete(); dat_q.delete();
      for (int c = 0; c < nconv; c++) begin
         d_q.push_back(int'($urandom_range(0, 20)));
         for (int k = 0; k < NUM_CH; k++) begin
            st_q.push_back(int'($urandom_range(0, max_stall)));
            dat_q.push_back(int'($urandom_range(0, (1 << DATA_W) - 1)));
         end
      end
   endtask

   task automatic run_conv(input string tag, input int nconv);
      build_model(nconv);
      run_until(sch_end + 3);
      check_events(tag);
      idle_inputs();
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, ".convst"}, CONVST_18, 1);
      chk({tag, ".rd"}, RD_18, 1);
      chk({tag, ".pd18"}, PD_18, 0);
      chk({tag, ".valid"}, out_valid, 0);
      chk({tag, ".data"}, out_data, 0);
      chk({tag, ".ch"}, out_ch, 0);
      chk({tag, ".busy"}, busy, 0);
      chk({tag, ".timeout"}, timeout_err, 0);
   endtask

   initial begin
      // Reset state (PD_in=1 but PD_18 must stay 0 in reset).
      repeat (3) step();
      check_reset_values("reset");
      Reset = 1'b1;
      step();
      chk("pd18_follow_on", PD_18, 1);
      repeat (2) step();

      // Fixed pattern, no backpressure, EOC 20 cycles after start.
      d_q = '{15};
      st_q = '{0, 0, 0, 0};
      dat_q = '{'h000, 'h111, 'h222, 'h333};
      run_conv("pattern", 1);
      $display("transaction pattern words=4 checks=%0d failures=%0d", checks, failures);
      repeat (3) step();

      // Word 1 stalled for 10 cycles.
      d_q = '{7};
      st_q = '{0, 10, 0, 2};
      dat_q = '{'hABC, 'h5A5, 'hFFF, 'h001};
      run_conv("stall", 1);
      $display("transaction stall checks=%0d failures=%0d", checks, failures);
      repeat (2) step();

      // Random single conversions.
      for (int r = 0; r < 5; r++) begin
         fill_random(1, 4);
         run_conv($sformatf("rand%0d", r), 1);
         $display("transaction rand%0d checks=%0d failures=%0d", r, checks, failures);
         repeat (int'($urandom_range(1, 4))) step();
      end

      // Continuous burst of three conversions.
      fill_random(3, 3);
      run_conv("continuous", 3);
      $display("transaction continuous convs=3 checks=%0d failures=%0d", checks, failures);
      repeat (2) step();

      // EOC never arrives.
      build_timeout();
      run_until(sch_end + 4);
      check_events("timeout");
      idle_inputs();
      $display("transaction timeout checks=%0d failures=%0d", checks, failures);
      repeat (2) step();

      // PD_in dropped during RD low.
      fill_random(1, 0);
      build_model(1);
      run_until(exp_rf[0] + 2);
      idle_inputs();
      PD_in = 1'b0;
      #1;
      chk("abort_rd.pd18", PD_18, 0);
      step();
      chk("abort_rd.rd", RD_18, 1);
      chk("abort_rd.valid", out_valid, 0);
      chk("abort_rd.busy", busy, 0);
      chk("abort_rd.convst", CONVST_18, 1);
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      chk("pd_start_ignored.busy", busy, 0);
      chk("pd_start_ignored.convst", CONVST_18, 1);
      PD_in = 1'b1;
      repeat (2) step();
      $display("transaction abort_rd checks=%0d failures=%0d", checks, failures);

      // PD_in dropped while a word waits in HOLD: the word is dropped.
      fill_random(1, 0);
      st_q[1] = 12;
      build_model(1);
      run_until(exp_rr[1] + 2);
      chk("abort_hold.valid_before", out_valid, 1);
      idle_inputs();
      PD_in = 1'b0;
      step();
      chk("abort_hold.valid", out_valid, 0);
      chk("abort_hold.busy", busy, 0);
      PD_in = 1'b1;
      repeat (3) step();
      chk("abort_hold.valid_after", out_valid, 0);
      chk("abort_hold.rd_after", RD_18, 1);
      $display("transaction abort_hold checks=%0d failures=%0d", checks, failures);

      // start and PD_in falling in the same cycle: stay idle.
      start = 1'b1;
      PD_in = 1'b0;
      step();
      start = 1'b0;
      step();
      chk("start_pd_same.busy", busy, 0);
      chk("start_pd_same.convst", CONVST_18, 1);
      PD_in = 1'b1;
      repeat (2) step();
      $display("transaction start_pd_same checks=%0d failures=%0d", checks, failures);

      // Reset pulsed mid-RD: outputs return to reset values without a clock.
      fill_random(1, 0);
      build_model(1);
      run_until(exp_rf[0] + 1);
      idle_inputs();
      #2;
      Reset = 1'b0;
      #1;
      check_reset_values("reset_mid_rd");
      repeat (2) step();
      Reset = 1'b1;
      repeat (2) step();

      // Recovery after reset.
      fill_random(1, 2);
      run_conv("recover", 1);
      $display("transaction recover checks=%0d failures=%0d", checks, failures);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
